// File: rtl/en_pulse_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | en_pulse_gen_if : button/mode inputs and EN/held outputs          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface en_pulse_gen_if;
  logic btn;
  logic mode;
  logic EN;
  logic held;

  modport master (output btn, output mode, input EN, input held);
  modport slave  (input btn, input mode, output EN, output held);
endinterface
`default_nettype wire

// File: rtl/en_pulse_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | en_pulse_gen : debounced push-button / auto-tick enable pulser    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module en_pulse_gen #(
  parameter int DB_CYCLES = 4,
  parameter int DIV       = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  en_pulse_gen_if.slave   bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int DW = $clog2(DIV);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [DW-1:0] C_DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] r_div;
  logic          r_en;
  logic          r_held;
  logic          w_fire;

  // r_sync2 is the only btn-derived signal the FSM may look at.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync2) begin
          w_state_nxt = PRESS_CHK;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_fire      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      HELD: begin
        if (!r_sync2) begin
          w_state_nxt = REL_CHK;
          w_cnt_nxt   = '0;
        end
      end
      REL_CHK: begin
        if (r_sync2) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_en    <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_held  <= (w_state_nxt == HELD) || (w_state_nxt == REL_CHK);
      if (bus.mode) begin
        r_div <= (r_div == C_DIV_LAST) ? '0 : r_div + DW'(1);
        r_en  <= (r_div == C_DIV_LAST);
      end else begin
        r_div <= '0;
        // A press landing right after a final tick is dropped so EN never stays high two cycles.
        r_en  <= w_fire && !r_en;
      end
    end
  end

  assign bus.EN   = r_en;
  assign bus.held = r_held;

endmodule
`default_nettype wire
